ppu_cpu_port: RTL and testbench

- CPU-side initiator for the PPU memory bus: implements the $2006 (PPUADDR) and $2007 (PPUDATA) register semantics.
- Converts single-cycle CPU register strobes into PPU bus read and write transactions.
- Sits between the CPU register decode and the PPU bus responder (CHR/VRAM with 1-cycle registered read latency).
- Owns the 14-bit VRAM address, the write toggle, the read buffer and auto-increment.

---
 rtl/ppu_cpu_port.sv | 146 ++++++++++++++
 tb/tb_ppu_cpu_port.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_cpu_port.sv
// CPU-side PPU bus initiator: $2006/$2007 register semantics, VRAM address,
// write toggle, buffered reads and auto-increment.
module ppu_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_sel_addr,
  input  logic              cpu_sel_data,
  input  logic              cpu_rw,
  input  logic [7:0]        cpu_data_i,
  output logic [7:0]        cpu_data_o,
  input  logic              inc32,
  input  logic              w_clear,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [7:0]        bus_data_o,
  input  logic [7:0]        bus_data_i,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] vaddr
);

  localparam int HI_W = ADDR_W - 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2,
    RD_CAP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   vaddr_q, vaddr_d;
  logic [HI_W-1:0]     tmp_hi_q, tmp_hi_d;
  logic                w_q, w_d;
  logic [7:0]          rd_buf_q, rd_buf_d;
  logic [7:0]          cpu_data_q, cpu_data_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                overrun_q, overrun_d;
  logic                addr_wr;
  logic                inc_en;
  logic                wr_cycle;
  logic [ADDR_W-1:0]   step;

  assign addr_wr  = cpu_sel_addr & ~cpu_rw;
  assign wr_cycle = (state_q == WR_REQ) && bus_grant;
  assign step     = inc32 ? ADDR_W'(32) : ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      vaddr_q    <= '0;
      tmp_hi_q   <= '0;
      w_q        <= 1'b0;
      rd_buf_q   <= '0;
      cpu_data_q <= '0;
      wr_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vaddr_q    <= vaddr_d;
      tmp_hi_q   <= tmp_hi_d;
      w_q        <= w_d;
      rd_buf_q   <= rd_buf_d;
      cpu_data_q <= cpu_data_d;
      wr_data_q  <= wr_data_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vaddr_d    = vaddr_q;
    tmp_hi_d   = tmp_hi_q;
    w_d        = w_q;
    rd_buf_d   = rd_buf_q;
    cpu_data_d = cpu_data_q;
    wr_data_d  = wr_data_q;
    overrun_d  = overrun_q;
    inc_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_sel_data) begin
          if (cpu_rw) begin
            cpu_data_d = rd_buf_q;
            state_d    = RD_REQ;
          end else begin
            wr_data_d = cpu_data_i;
            state_d   = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (bus_grant) begin
          inc_en  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (bus_grant) begin
          state_d = RD_CAP;
        end
      end
      RD_CAP: begin
        rd_buf_d = bus_data_i;
        inc_en   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (cpu_sel_data || addr_wr)) begin
      overrun_d = 1'b1;
    end

    if (inc_en) begin
      vaddr_d = vaddr_q + step;
    end

    // A $2006 write takes priority over a coincident auto-increment; a
    // coincident w_clear turns it into a first write.
    if (addr_wr) begin
      if (w_q && !w_clear) begin
        vaddr_d = {tmp_hi_q, cpu_data_i};
        w_d     = 1'b0;
      end else begin
        tmp_hi_d = cpu_data_i[HI_W-1:0];
        w_d      = 1'b1;
      end
    end else if (w_clear) begin
      w_d = 1'b0;
    end
  end

  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;
  assign vaddr      = vaddr_q;
  assign bus_addr   = vaddr_q;
  assign bus_rw     = ~wr_cycle;
  assign bus_data_o = wr_cycle ? wr_data_q : 8'h00;
  assign cpu_data_o = cpu_data_q;

endmodule

// File: tb/tb_ppu_cpu_port.sv
// Directed self-checking bench for ppu_cpu_port with a 1-cycle registered
// memory responder that logs every bus write cycle.
module tb_ppu_cpu_port;

  logic        clk;
  logic        rst;
  logic        cpu_sel_addr;
  logic        cpu_sel_data;
  logic        cpu_rw;
  logic [7:0]  cpu_data_i;
  logic [7:0]  cpu_data_o;
  logic        inc32;
  logic        w_clear;
  logic        bus_grant;
  logic [13:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i;
  logic        busy;
  logic        overrun;
  logic [13:0] vaddr;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [0:16383];
  logic [13:0] logAddr [$];
  logic [7:0]  logData [$];

  ppu_cpu_port #(.ADDR_W(14)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_sel_addr (cpu_sel_addr),
    .cpu_sel_data (cpu_sel_data),
    .cpu_rw       (cpu_rw),
    .cpu_data_i   (cpu_data_i),
    .cpu_data_o   (cpu_data_o),
    .inc32        (inc32),
    .w_clear      (w_clear),
    .bus_grant    (bus_grant),
    .bus_addr     (bus_addr),
    .bus_rw       (bus_rw),
    .bus_data_o   (bus_data_o),
    .bus_data_i   (bus_data_i),
    .busy         (busy),
    .overrun      (overrun),
    .vaddr        (vaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: commits write cycles and returns read data one cycle later.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus_rw == 1'b0) begin
        mem[bus_addr] <= bus_data_o;
        logAddr.push_back(bus_addr);
        logData.push_back(bus_data_o);
      end
      bus_data_i <= mem[bus_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cpuWriteAddr(input logic [7:0] d, input logic clr);
    @(negedge clk);
    cpu_sel_addr = 1'b1; cpu_rw = 1'b0; cpu_data_i = d; w_clear = clr;
    @(negedge clk);
    cpu_sel_addr = 1'b0; cpu_rw = 1'b1; w_clear = 1'b0;
  endtask

  task automatic cpuWriteData(input logic [7:0] d);
    @(negedge clk);
    cpu_sel_data = 1'b1; cpu_rw = 1'b0; cpu_data_i = d;
    @(negedge clk);
    cpu_sel_data = 1'b0; cpu_rw = 1'b1;
  endtask

  task automatic cpuReadData();
    @(negedge clk);
    cpu_sel_data = 1'b1; cpu_rw = 1'b1;
    @(negedge clk);
    cpu_sel_data = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk);
    w_clear = 1'b1;
    @(negedge clk);
    w_clear = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({vaddr, bus_addr, bus_rw, bus_data_o, cpu_data_o, busy, overrun} !==
        {14'h0, 14'h0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: vaddr=%h bus_addr=%h rw=%b bdo=%h cdo=%h busy=%b ovr=%b",
               vaddr, bus_addr, bus_rw, bus_data_o, cpu_data_o, busy, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({vaddr, bus_rw, busy, overrun} !== {14'h0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL post_reset: vaddr=%h rw=%b busy=%b ovr=%b, required 0000 1 0 0",
               vaddr, bus_rw, busy, overrun);
    end
  endtask

  task automatic test_address_load();
    cpuWriteAddr(8'h21, 1'b0);
    cpuWriteAddr(8'h08, 1'b0);
    tests++;
    if (vaddr !== 14'h2108) begin
      fails++; $display("FAIL addr_pair: vaddr=%h required 2108", vaddr);
    end
    cpuWriteAddr(8'h3F, 1'b0);
    tests++;
    if (vaddr !== 14'h2108) begin
      fails++; $display("FAIL addr_half: vaddr=%h required 2108", vaddr);
    end
    cpuWriteAddr(8'h05, 1'b0);
    tests++;
    if (vaddr !== 14'h3F05) begin
      fails++; $display("FAIL addr_second: vaddr=%h required 3f05", vaddr);
    end
    cpuWriteAddr(8'h3F, 1'b0);
    pulseClear();
    cpuWriteAddr(8'h22, 1'b0);
    cpuWriteAddr(8'h10, 1'b0);
    tests++;
    if (vaddr !== 14'h2210) begin
      fails++; $display("FAIL addr_wclear: vaddr=%h required 2210", vaddr);
    end
    cpuWriteAddr(8'h3F, 1'b0);
    cpuWriteAddr(8'h15, 1'b1);
    cpuWriteAddr(8'h00, 1'b0);
    tests++;
    if (vaddr !== 14'h1500) begin
      fails++; $display("FAIL addr_wclear_coincident: vaddr=%h required 1500", vaddr);
    end
  endtask

  task automatic test_write_increment();
    int base;
    inc32 = 1'b0;
    cpuWriteAddr(8'h20, 1'b0);
    cpuWriteAddr(8'h00, 1'b0);
    base = logAddr.size();
    cpuWriteData(8'hAA);
    tests++;
    if ({bus_rw, bus_addr, bus_data_o, busy} !== {1'b0, 14'h2000, 8'hAA, 1'b1}) begin
      fails++;
      $display("FAIL wr_cycle: rw=%b addr=%h data=%h busy=%b, required 0 2000 aa 1",
               bus_rw, bus_addr, bus_data_o, busy);
    end
    @(negedge clk);
    tests++;
    if ({bus_rw, busy, vaddr} !== {1'b1, 1'b0, 14'h2001}) begin
      fails++;
      $display("FAIL wr_done: rw=%b busy=%b vaddr=%h, required 1 0 2001", bus_rw, busy, vaddr);
    end
    cpuWriteData(8'hBB);
    waitIdle("wr_bb");
    tests++;
    if (logAddr.size() != base + 2) begin
      fails++;
      $display("FAIL wr_count: %0d write cycles, required 2", logAddr.size() - base);
    end else if ({logAddr[base], logData[base], logAddr[base+1], logData[base+1]} !==
                 {14'h2000, 8'hAA, 14'h2001, 8'hBB}) begin
      fails++;
      $display("FAIL wr_log: %h/%h %h/%h, required 2000/aa 2001/bb",
               logAddr[base], logData[base], logAddr[base+1], logData[base+1]);
    end
    tests++;
    if (vaddr !== 14'h2002) begin
      fails++; $display("FAIL wr_final_vaddr: vaddr=%h required 2002", vaddr);
    end
  endtask

  task automatic test_buffered_read();
    logic [7:0]  expData [4];
    logic [13:0] expAddr [4];
    expData = '{8'h00, 8'h11, 8'h33, 8'h44};
    expAddr = '{14'h2420, 14'h2440, 14'h2460, 14'h2480};
    inc32 = 1'b1;
    cpuWriteAddr(8'h24, 1'b0);
    cpuWriteAddr(8'h00, 1'b0);
    cpuWriteData(8'h11); waitIdle("pre_11");
    cpuWriteData(8'h33); waitIdle("pre_33");
    cpuWriteData(8'h44); waitIdle("pre_44");
    cpuWriteAddr(8'h24, 1'b0);
    cpuWriteAddr(8'h01, 1'b0);
    cpuWriteData(8'h22); waitIdle("pre_22");
    cpuWriteAddr(8'h24, 1'b0);
    cpuWriteAddr(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cpuReadData();
      tests++;
      if (cpu_data_o !== expData[i]) begin
        fails++;
        $display("FAIL rd_data%0d: cpu_data_o=%h required %h", i, cpu_data_o, expData[i]);
      end
      waitIdle("rd");
      tests++;
      if (vaddr !== expAddr[i]) begin
        fails++;
        $display("FAIL rd_vaddr%0d: vaddr=%h required %h", i, vaddr, expAddr[i]);
      end
    end
    inc32 = 1'b0;
  endtask

  task automatic test_grant_stall();
    int base;
    @(negedge clk);
    bus_grant = 1'b0;
    cpuWriteAddr(8'h12, 1'b0);
    cpuWriteAddr(8'h34, 1'b0);
    base = logAddr.size();
    cpuWriteData(8'h55);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({busy, bus_rw, vaddr} !== {1'b1, 1'b1, 14'h1234}) begin
        fails++;
        $display("FAIL stall_hold%0d: busy=%b rw=%b vaddr=%h, required 1 1 1234",
                 i, busy, bus_rw, vaddr);
      end
      @(negedge clk);
    end
    bus_grant = 1'b1;
    @(negedge clk);
    bus_grant = 1'b0;
    #1;
    tests++;
    if ({busy, vaddr} !== {1'b0, 14'h1235}) begin
      fails++;
      $display("FAIL stall_release: busy=%b vaddr=%h, required 0 1235", busy, vaddr);
    end
    tests++;
    if (logAddr.size() != base + 1) begin
      fails++;
      $display("FAIL stall_count: %0d write cycles, required 1", logAddr.size() - base);
    end else if ({logAddr[base], logData[base]} !== {14'h1234, 8'h55}) begin
      fails++;
      $display("FAIL stall_log: %h/%h required 1234/55", logAddr[base], logData[base]);
    end
    bus_grant = 1'b1;
  endtask

  task automatic test_overrun_wrap();
    int base;
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL ovr_initial: overrun=%b required 0", overrun);
    end
    cpuWriteAddr(8'h3F, 1'b0);
    cpuWriteAddr(8'hFF, 1'b0);
    bus_grant = 1'b0;
    base = logAddr.size();
    cpuWriteData(8'h66);
    cpuWriteData(8'h99);
    tests++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL ovr_set: overrun=%b required 1", overrun);
    end
    bus_grant = 1'b1;
    waitIdle("ovr");
    repeat (3) @(negedge clk);
    tests++;
    if (logAddr.size() != base + 1) begin
      fails++;
      $display("FAIL ovr_count: %0d write cycles, required 1", logAddr.size() - base);
    end else if ({logAddr[base], logData[base]} !== {14'h3FFF, 8'h66}) begin
      fails++;
      $display("FAIL ovr_log: %h/%h required 3fff/66", logAddr[base], logData[base]);
    end
    tests++;
    if ({vaddr, overrun} !== {14'h0000, 1'b1}) begin
      fails++;
      $display("FAIL wrap: vaddr=%h overrun=%b, required 0000 1", vaddr, overrun);
    end
  endtask

  task automatic test_async_reset();
    int base;
    @(negedge clk);
    bus_grant = 1'b0;
    cpuWriteAddr(8'h05, 1'b0);
    cpuWriteAddr(8'h00, 1'b0);
    cpuReadData();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rst_rd_pending: busy=%b required 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, bus_rw, vaddr, overrun} !== {1'b0, 1'b1, 14'h0, 1'b0}) begin
      fails++;
      $display("FAIL rst_rd_abort: busy=%b rw=%b vaddr=%h ovr=%b, required 0 1 0000 0",
               busy, bus_rw, vaddr, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    cpuWriteAddr(8'h05, 1'b0);
    cpuWriteAddr(8'h00, 1'b0);
    base = logAddr.size();
    cpuWriteData(8'h77);
    bus_grant = 1'b1;
    #1;
    tests++;
    if (bus_rw !== 1'b0) begin
      fails++; $display("FAIL rst_wr_presented: rw=%b required 0", bus_rw);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({bus_rw, bus_data_o, bus_addr, busy, vaddr, cpu_data_o} !==
        {1'b1, 8'h00, 14'h0, 1'b0, 14'h0, 8'h00}) begin
      fails++;
      $display("FAIL rst_wr_abort: rw=%b bdo=%h addr=%h busy=%b vaddr=%h cdo=%h",
               bus_rw, bus_data_o, bus_addr, busy, vaddr, cpu_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ((logAddr.size() != base) || (vaddr !== 14'h0) || (busy !== 1'b0)) begin
      fails++;
      $display("FAIL rst_no_write: writes=%0d vaddr=%h busy=%b, required 0 0000 0",
               logAddr.size() - base, vaddr, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_sel_addr = 1'b0;
    cpu_sel_data = 1'b0;
    cpu_rw = 1'b1;
    cpu_data_i = 8'h00;
    inc32 = 1'b0;
    w_clear = 1'b0;
    bus_grant = 1'b1;
    test_reset();
    test_address_load();
    test_write_increment();
    test_buffered_read();
    test_grant_stall();
    test_overrun_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
